// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, trap/interrupt controller and prescaled mtime timer
module csr_trap_unit #(
    parameter int          NUM_EXT_IRQ    = 4,
    parameter int          TIMER_PRESCALE = 1,
    parameter bit          VECTORED_EN    = 1'b1,
    parameter logic [31:0] MTVEC_RESET    = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [11:0]            csr_addr,
    input  logic [1:0]             csr_op,
    input  logic [31:0]            csr_wdata,
    output logic [31:0]            csr_rdata,
    output logic                   csr_illegal,
    input  logic                   exc_req,
    input  logic [4:0]             exc_cause,
    input  logic [31:0]            exc_pc,
    input  logic [31:0]            exc_tval,
    input  logic                   mret,
    input  logic                   irq_take,
    input  logic [31:0]            irq_pc,
    output logic                   irq_pending,
    output logic [31:0]            trap_target,
    output logic [1:0]             priv,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    output logic [31:0]            satp,
    output logic                   tlb_flush
);
    localparam int PW = TIMER_PRESCALE > 1 ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [31:0] TVMASK = VECTORED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;

    logic                   st_mie, st_mpie, msip;
    logic [1:0]             st_mpp;
    logic [31:0]            mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0]            mtime, mtimecmp;
    logic [PW-1:0]          pre;
    logic [NUM_EXT_IRQ-1:0] pend;

    logic        meip, mtip, mapped, wr, irq_go, vec;
    logic [4:0]  irq_code;
    logic [31:0] mstatus_v, mip_v, en, claim_id, old, wval, base;

    assign meip      = |pend;
    assign mtip      = mtime >= mtimecmp;
    assign mstatus_v = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mip_v     = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
    assign en        = mip_v & mie_r;

    always_comb begin
        claim_id = '0;
        for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
            if (pend[i]) claim_id = 32'(i + 1);
    end

    always_comb begin
        old    = '0;
        mapped = 1'b1;
        case (csr_addr)
            12'h300: old = mstatus_v;
            12'h304: old = mie_r;
            12'h305: old = mtvec;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h343: old = mtval;
            12'h344: old = mip_v;
            12'h180: old = satp;
            12'h7C0: old = claim_id;
            12'h7C1: old = mtimecmp[31:0];
            12'h7C2: old = mtimecmp[63:32];
            12'h7C3: old = mtime[31:0];
            12'h7C4: old = mtime[63:32];
            default: mapped = 1'b0;
        endcase
    end

    assign csr_rdata   = old;
    assign csr_illegal = (csr_op != 2'b00) && (!mapped || (priv == 2'b00 && csr_addr[9:8] != 2'b00));
    assign wval        = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? (old | csr_wdata) : (old & ~csr_wdata);
    assign irq_pending = (priv == 2'b00 || st_mie) && (en != 32'b0);
    assign irq_go      = irq_take && irq_pending;
    // Set/clear with a zero operand is a pure read; any trap event drops the write
    assign wr          = (csr_op != 2'b00) && !csr_illegal && !(csr_op[1] && csr_wdata == 32'b0)
                         && !exc_req && !mret && !irq_go;
    assign irq_code    = en[11] ? 5'd11 : en[3] ? 5'd3 : 5'd7;
    assign base        = {mtvec[31:2], 2'b00};
    assign vec         = mtvec[1:0] == 2'b01;
    assign trap_target = exc_req ? base : mret ? mepc : (irq_go && vec) ? base + {25'b0, irq_code, 2'b00} : base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_mie    <= 1'b0;
            st_mpie   <= 1'b0;
            st_mpp    <= 2'b00;
            mie_r     <= '0;
            mtvec     <= MTVEC_RESET & TVMASK;
            mscratch  <= '0;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            msip      <= 1'b0;
            satp      <= '0;
            tlb_flush <= 1'b0;
            pend      <= '0;
            pre       <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            priv      <= 2'b11;
        end else begin
            tlb_flush <= wr && csr_addr == 12'h180;
            for (int i = 0; i < NUM_EXT_IRQ; i++)
                if (ext_irq[i]) pend[i] <= 1'b1;
                else if (wr && csr_addr == 12'h7C0 && wval == 32'(i + 1)) pend[i] <= 1'b0;
            if (wr && csr_addr == 12'h7C3) begin
                mtime <= {mtime[63:32], wval};
                pre   <= '0;
            end else if (wr && csr_addr == 12'h7C4) begin
                mtime <= {wval, mtime[31:0]};
                pre   <= '0;
            end else if (pre == PW'(TIMER_PRESCALE - 1)) begin
                mtime <= mtime + 64'd1;
                pre   <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
            if (exc_req || (irq_go && !mret)) begin
                mepc    <= (exc_req ? exc_pc : irq_pc) & ~32'h3;
                mcause  <= exc_req ? {27'b0, exc_cause} : {1'b1, 26'b0, irq_code};
                mtval   <= exc_req ? exc_tval : 32'b0;
                st_mpp  <= priv;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                priv    <= 2'b11;
            end else if (mret) begin
                priv    <= st_mpp;
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                st_mpp  <= 2'b00;
            end else if (wr) begin
                case (csr_addr)
                    12'h300: begin
                        st_mie  <= wval[3];
                        st_mpie <= wval[7];
                        st_mpp  <= wval[12:11] == 2'b11 ? 2'b11 : 2'b00;
                    end
                    12'h304: mie_r <= wval & 32'h888;
                    12'h305: mtvec <= wval & TVMASK;
                    12'h340: mscratch <= wval;
                    12'h341: mepc <= wval & ~32'h3;
                    12'h342: mcause <= wval;
                    12'h343: mtval <= wval;
                    12'h344: msip <= wval[3];
                    12'h180: satp <= wval;
                    12'h7C1: mtimecmp[31:0] <= wval;
                    12'h7C2: mtimecmp[63:32] <= wval;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed scenarios plus randomized traffic against a behavioural CSR/trap model
module tb_csr_trap_unit;
    localparam int PRE = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, csr_rdata, exc_pc, exc_tval, irq_pc, trap_target, satp;
    logic        csr_illegal, exc_req, mret, irq_take, irq_pending, tlb_flush;
    logic [4:0]  exc_cause;
    logic [1:0]  priv;
    logic [3:0]  ext_irq;

    csr_trap_unit #(.NUM_EXT_IRQ(4), .TIMER_PRESCALE(PRE), .VECTORED_EN(1'b1), .MTVEC_RESET(32'h0000_0201)) dut (
        .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .exc_req(exc_req), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret), .irq_take(irq_take), .irq_pc(irq_pc),
        .irq_pending(irq_pending), .trap_target(trap_target), .priv(priv), .ext_irq(ext_irq),
        .satp(satp), .tlb_flush(tlb_flush)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    logic [1:0]  m_priv, m_mpp;
    logic        m_ie, m_pie, m_msip, m_tlbf;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_satp;
    logic [63:0] m_cmp, t_base, t_cyc;
    bit          m_lat[4];
    logic [11:0] amap[14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'h180, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_priv = 3; m_mpp = 0; m_ie = 0; m_pie = 0; m_msip = 0; m_tlbf = 0;
        m_mie = 0; m_mtvec = 32'h201; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_satp = 0;
        m_cmp = '1; t_base = 0; t_cyc = 0;
        foreach (m_lat[i]) m_lat[i] = 0;
    endtask

    function automatic logic [63:0] m_time();
        return t_base + t_cyc / PRE;
    endfunction

    function automatic logic [31:0] m_mip();
        logic any = 0;
        foreach (m_lat[i]) any |= m_lat[i];
        return (any ? 32'd2048 : 0) + (m_time() >= m_cmp ? 32'd128 : 0) + (m_msip ? 32'd8 : 0);
    endfunction

    function automatic logic [32:0] m_read(input logic [11:0] a);
        logic [63:0] t = m_time();
        int id = 0;
        for (int i = 3; i >= 0; i--) if (m_lat[i]) id = i + 1;
        case (a)
            12'h300: return {1'b1, 32'(m_mpp) * 2048 + (m_pie ? 32'd128 : 0) + (m_ie ? 32'd8 : 0)};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip()};
            12'h180: return {1'b1, m_satp};
            12'h7C0: return {1'b1, 32'(id)};
            12'h7C1: return {1'b1, m_cmp[31:0]};
            12'h7C2: return {1'b1, m_cmp[63:32]};
            12'h7C3: return {1'b1, t[31:0]};
            12'h7C4: return {1'b1, t[63:32]};
            default: return 33'h0;
        endcase
    endfunction

    task automatic idle();
        csr_addr = 0; csr_op = 0; csr_wdata = 0; exc_req = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        mret = 0; irq_take = 0; irq_pc = 0; ext_irq = 0;
    endtask

    task automatic tick();
        logic [32:0] r;
        logic [31:0] old, wv, tgt, en, base;
        logic        ill, pnd, go, wr;
        logic [4:0]  code;
        logic [63:0] t;
        #1;
        t = m_time();
        r = m_read(csr_addr);
        old = r[31:0];
        ill = csr_op != 0 && (!r[32] || (m_priv == 0 && csr_addr[9:8] != 0));
        en = m_mip() & m_mie;
        pnd = (m_priv == 0 || m_ie) && en != 0;
        code = en[11] ? 5'd11 : en[3] ? 5'd3 : 5'd7;
        go = irq_take && pnd;
        wv = csr_op == 1 ? csr_wdata : csr_op == 2 ? (old | csr_wdata) : (old & ~csr_wdata);
        wr = csr_op != 0 && !ill && !(csr_op >= 2 && csr_wdata == 0) && !exc_req && !mret && !go;
        base = m_mtvec & ~32'h3;
        tgt = exc_req ? base : mret ? m_mepc : (go && m_mtvec[1:0] == 1) ? base + 4 * 32'(code) : base;
        check("rdata", csr_rdata, old);
        check("illegal", csr_illegal, ill);
        check("irq_pending", irq_pending, pnd);
        check("priv", priv, m_priv);
        check("satp", satp, m_satp);
        check("tlb_flush", tlb_flush, m_tlbf);
        if (exc_req || mret || go) check("trap_target", trap_target, tgt);
        @(posedge clk);
        t_cyc++;
        for (int i = 0; i < 4; i++)
            if (ext_irq[i]) m_lat[i] = 1;
            else if (wr && csr_addr == 12'h7C0 && wv == 32'(i + 1)) m_lat[i] = 0;
        m_tlbf = wr && csr_addr == 12'h180;
        if (exc_req || (go && !mret)) begin
            m_mepc = (exc_req ? exc_pc : irq_pc) & ~32'h3;
            m_mcause = exc_req ? 32'(exc_cause) : 32'h8000_0000 + 32'(code);
            m_mtval = exc_req ? exc_tval : 0;
            m_mpp = m_priv; m_pie = m_ie; m_ie = 0; m_priv = 3;
        end else if (mret) begin
            m_priv = m_mpp; m_ie = m_pie; m_pie = 1; m_mpp = 0;
        end else if (wr) begin
            case (csr_addr)
                12'h300: begin m_ie = wv[3]; m_pie = wv[7]; m_mpp = wv[12:11] == 3 ? 2'd3 : 2'd0; end
                12'h304: m_mie = wv & 32'h888;
                12'h305: m_mtvec = wv;
                12'h340: m_mscratch = wv;
                12'h341: m_mepc = wv & ~32'h3;
                12'h342: m_mcause = wv;
                12'h343: m_mtval = wv;
                12'h344: m_msip = wv[3];
                12'h180: m_satp = wv;
                12'h7C1: m_cmp[31:0] = wv;
                12'h7C2: m_cmp[63:32] = wv;
                12'h7C3: begin t_base = {t[63:32], wv}; t_cyc = 0; end
                12'h7C4: begin t_base = {wv, t[31:0]}; t_cyc = 0; end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle(); csr_op = op; csr_addr = a; csr_wdata = d;
        tick(); idle();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle(); csr_addr = a;
        #1 check(tag, csr_rdata, exp);
        tick();
    endtask

    task automatic exc(input logic [4:0] c, input logic [31:0] pc);
        idle(); exc_req = 1; exc_cause = c; exc_pc = pc; exc_tval = 32'h55;
        tick(); idle();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        reset = 0;
        m_reset();
        rd("rst_mstatus", 12'h300, 0);
        rd("rst_mtvec", 12'h305, 32'h201);
        rd("rst_mtimecmp", 12'h7C1, 32'hFFFF_FFFF);
        #1 check("rst_priv", priv, 3);
        check("rst_pending", irq_pending, 0);
        tick();

        csr_do(1, 12'h305, 32'h8000_0001);
        idle(); mret = 1; tick(); idle();
        exc_req = 1; exc_cause = 8; exc_pc = 32'h1000;
        #1 check("u_priv", priv, 0);
        check("exc_target", trap_target, 32'h8000_0000);
        tick(); idle();
        rd("exc_mepc", 12'h341, 32'h1000);
        rd("exc_mcause", 12'h342, 8);
        rd("exc_mstatus", 12'h300, 0);
        #1 check("exc_priv", priv, 3);
        mret = 1;
        #1 check("mret_target", trap_target, 32'h1000);
        tick(); idle();
        #1 check("mret_priv", priv, 0);
        exc(2, 32'h1004);

        csr_do(1, 12'h304, 32'h800);
        csr_do(1, 12'h305, 32'h101);
        csr_do(2, 12'h300, 32'h8);
        ext_irq = 4'b0100; tick(); idle();
        irq_take = 1; irq_pc = 32'h2000;
        #1 check("ext_pending", irq_pending, 1);
        check("ext_target", trap_target, 32'h12C);
        tick(); idle();
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_claim", 12'h7C0, 3);
        csr_do(1, 12'h7C0, 3);
        rd("ext_mip", 12'h344, 0);
        csr_do(2, 12'h300, 32'h8);
        #1 check("ext_cleared", irq_pending, 0);
        tick();

        csr_do(1, 12'h7C2, 0);
        csr_do(1, 12'h7C1, 5);
        csr_do(1, 12'h304, 32'h80);
        csr_do(1, 12'h7C4, 0);
        csr_do(1, 12'h7C3, 0);
        csr_addr = 12'h344;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1 if (k >= 19) check("mtip_edge", csr_rdata[7], k == 20);
        end
        csr_do(1, 12'h304, 32'h88);
        csr_do(1, 12'h344, 32'h8);
        irq_take = 1; irq_pc = 32'h3000;
        #1 check("msi_target", trap_target, 32'h10C);
        tick(); idle();
        rd("msi_mcause", 12'h342, 32'h8000_0003);
        csr_do(1, 12'h344, 0);
        csr_do(1, 12'h7C2, 32'hFFFF_FFFF);

        csr_do(2, 12'h300, 32'h8);
        csr_addr = 12'h300;
        #1 check("csrrs_mie", csr_rdata[3], 1);
        tick();
        csr_do(3, 12'h300, 32'h8);
        csr_addr = 12'h300;
        #1 check("csrrc_mie", csr_rdata[3], 0);
        tick();
        csr_do(1, 12'h340, 32'h1234);
        csr_do(1, 12'h300, 0);
        idle(); mret = 1; tick(); idle();
        csr_op = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
        #1 check("u_illegal", csr_illegal, 1);
        tick(); idle();
        csr_do(1, 12'h340, 32'hDEAD);
        exc(3, 32'h4000);
        rd("u_nowrite", 12'h340, 32'h1234);

        idle(); csr_op = 1; csr_addr = 12'h340; csr_wdata = 32'h5555; exc_req = 1; exc_cause = 3;
        tick(); idle();
        rd("exc_drop", 12'h340, 32'h1234);
        csr_do(1, 12'h180, 32'hABCD);
        #1 check("flush_hi", tlb_flush, 1);
        check("satp_val", satp, 32'hABCD);
        tick();
        #1 check("flush_lo", tlb_flush, 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            idle();
            csr_op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            csr_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : amap[$urandom_range(0, 13)];
            csr_wdata = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
            if (csr_addr == 12'h7C0) csr_wdata = $urandom_range(0, 5);
            if (csr_addr == 12'h7C2 || csr_addr == 12'h7C4) csr_wdata = $urandom_range(0, 1);
            exc_req = $urandom_range(0, 19) == 0;
            exc_cause = 5'($urandom); exc_pc = $urandom; exc_tval = $urandom;
            mret = $urandom_range(0, 19) == 0;
            irq_take = $urandom_range(0, 3) == 0;
            irq_pc = $urandom;
            ext_irq = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            tick();
        end

        exc(2, 32'h5000);
        csr_do(1, 12'h304, 32'h8);
        csr_do(1, 12'h344, 32'h8);
        csr_do(2, 12'h300, 32'h8);
        idle(); exc_req = 1; exc_pc = 32'h6000;
        #2 reset = 1;
        @(negedge clk);
        @(negedge clk);
        idle();
        reset = 0;
        m_reset();
        #1 check("post_rst_pending", irq_pending, 0);
        check("post_rst_priv", priv, 3);
        tick();
        rd("post_rst_mepc", 12'h341, 0);
        rd("post_rst_mip", 12'h344, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
